mod_n_counter: RTL

MOD_N_COUNTER -- requirements
Module: mod_n_counter

---
 rtl/mod_n_counter_if.sv | 26 ++
 rtl/mod_n_counter.sv | 84 ++++++++
 2 files changed

// File: rtl/mod_n_counter_if.sv
// Control and status bundle for the modulo-N up/down counter.
// The bench or parent block is the master; the counter is the slave.
interface mod_n_counter_if #(
    parameter int WIDTH  = 4,
    parameter int WRAP_W = 8
);
    logic              clear;
    logic              load;
    logic              mode;
    logic              enable;
    logic [WIDTH-1:0]  data_in;
    logic [WIDTH-1:0]  data_out;
    logic              tc;
    logic              load_err;
    logic [WRAP_W-1:0] wrap_cnt;

    modport master (
        output clear, load, mode, enable, data_in,
        input  data_out, tc, load_err, wrap_cnt
    );

    modport slave (
        input  clear, load, mode, enable, data_in,
        output data_out, tc, load_err, wrap_cnt
    );
endinterface

// File: rtl/mod_n_counter.sv
// Modulo-N up/down counter with clamped load, terminal count and a
// saturating wrap-event counter.
module mod_n_counter #(
    parameter int MODULUS = 12,
    parameter int WIDTH   = 4,
    parameter int WRAP_W  = 8
) (
    input logic           clk,
    input logic           reset,
    mod_n_counter_if.slave bus
);
    localparam int XW = WIDTH + 1;
    localparam logic [XW-1:0] MOD_X  = XW'(MODULUS);
    localparam logic [XW-1:0] LAST_X = XW'(MODULUS - 1);
    localparam logic [XW-1:0] ONE_X  = XW'(1);
    localparam logic [WRAP_W-1:0] WRAP_MAX = '1;
    localparam logic [WRAP_W-1:0] WRAP_ONE = WRAP_W'(1);

    logic [WIDTH-1:0]  count_q, count_d;
    logic [WRAP_W-1:0] wrap_q, wrap_d;
    logic              err_q, err_d;

    logic [XW-1:0] cnt_x;
    logic [XW-1:0] din_x;
    logic [XW-1:0] next_x;
    logic          at_top;
    logic          at_bot;
    logic          wrap_evt;

    // One extra bit keeps MODULUS == 2**WIDTH representable.
    always_comb begin
        cnt_x    = {1'b0, count_q};
        din_x    = {1'b0, bus.data_in};
        at_top   = (cnt_x == LAST_X);
        at_bot   = (cnt_x == '0);
        next_x   = cnt_x;
        count_d  = count_q;
        wrap_d   = wrap_q;
        err_d    = 1'b0;
        wrap_evt = 1'b0;

        if (bus.clear) begin
            count_d = '0;
            wrap_d  = '0;
        end else if (bus.load) begin
            if (din_x < MOD_X) begin
                count_d = bus.data_in;
            end else begin
                count_d = LAST_X[WIDTH-1:0];
                err_d   = 1'b1;
            end
        end else if (bus.enable) begin
            if (bus.mode) begin
                wrap_evt = at_top;
                next_x   = at_top ? '0 : cnt_x + ONE_X;
            end else begin
                wrap_evt = at_bot;
                next_x   = at_bot ? LAST_X : cnt_x - ONE_X;
            end
            count_d = next_x[WIDTH-1:0];
            if (wrap_evt && (wrap_q != WRAP_MAX)) begin
                wrap_d = wrap_q + WRAP_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            wrap_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign bus.data_out = count_q;
    assign bus.wrap_cnt = wrap_q;
    assign bus.load_err = err_q;
    assign bus.tc       = bus.enable &
                          ((bus.mode & at_top) | (~bus.mode & at_bot));
endmodule
